// File: rtl/if_stage_if.sv
// Pre-IF / ICache / decode signals around the fetch stage.
// master drives the stage inputs (pipeline or bench), slave is the fetch stage itself.
interface if_stage_if;
  logic [31:0] nextpc;
  logic [5:0]  ps_to_fs_bus;
  logic        inst_valid;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        ds_allowin;
  logic        flush;
  logic        ds_ex;
  logic        es_ex;
  logic        m1s_ex;
  logic        fs_allowin;
  logic [31:0] fs_pc;
  logic        fs_to_ds_valid;
  logic [69:0] fs_to_ds_bus;

  modport master (
    output nextpc, ps_to_fs_bus, inst_valid, inst_addr_ok, inst_data_ok,
           inst_rdata, ds_allowin, flush, ds_ex, es_ex, m1s_ex,
    input  fs_allowin, fs_pc, fs_to_ds_valid, fs_to_ds_bus
  );

  modport slave (
    input  nextpc, ps_to_fs_bus, inst_valid, inst_addr_ok, inst_data_ok,
           inst_rdata, ds_allowin, flush, ds_ex, es_ex, m1s_ex,
    output fs_allowin, fs_pc, fs_to_ds_valid, fs_to_ds_bus
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: holds one fetched PC, waits for its ICache data (or an
// exception), and hands {ex, exctype, inst, pc} to decode with a valid/allowin handshake.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'hbfbffffc
) (
  input  logic      clk,
  input  logic      reset,
  if_stage_if.slave bus
);
  // Handshake: a stage transfers on a cycle where its valid and the consumer's
  // allowin are both high; a fetch request transfers when inst_valid & inst_addr_ok.

  logic        fs_valid_q, fs_valid_d;
  logic [31:0] fs_pc_q, fs_pc_d;
  logic        fs_ex_q, fs_ex_d;
  logic [4:0]  fs_exctype_q, fs_exctype_d;
  logic        pending_q, pending_d;
  logic        discard_q, discard_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] inst_buf_q, inst_buf_d;

  logic        ex_block;
  logic        fs_ready_go;
  logic        fs_allowin;
  logic        fs_to_ds_valid;
  logic        req_fire;
  logic        adel_fire;
  logic        transfer;
  logic        data_take;
  logic        data_drop;
  logic [31:0] fs_inst;

  always_comb begin
    ex_block       = bus.ds_ex | bus.es_ex | bus.m1s_ex;
    data_drop      = discard_q & bus.inst_data_ok;
    data_take      = pending_q & bus.inst_data_ok & ~discard_q;
    fs_ready_go    = fs_valid_q & (buf_valid_q | (bus.inst_data_ok & ~discard_q)
                                   | (fs_ex_q & ~pending_q));
    fs_allowin     = ~fs_valid_q | (fs_ready_go & bus.ds_allowin);
    fs_to_ds_valid = fs_valid_q & fs_ready_go & ~bus.flush;
    transfer       = fs_to_ds_valid & bus.ds_allowin;
    req_fire       = bus.inst_valid & bus.inst_addr_ok & fs_allowin;
    adel_fire      = fs_allowin & (bus.nextpc[1:0] != 2'b00) & ~ex_block
                     & ~bus.flush & ~req_fire;
    if (fs_ex_q)
      fs_inst = 32'h0;
    else if (buf_valid_q)
      fs_inst = inst_buf_q;
    else
      fs_inst = bus.inst_rdata;
  end

  // Later assignments win: capture, then transfer, then flush, then a new fire.
  always_comb begin
    fs_valid_d   = fs_valid_q;
    fs_pc_d      = fs_pc_q;
    fs_ex_d      = fs_ex_q;
    fs_exctype_d = fs_exctype_q;
    pending_d    = pending_q;
    discard_d    = discard_q;
    buf_valid_d  = buf_valid_q;
    inst_buf_d   = inst_buf_q;

    if (data_drop)
      discard_d = 1'b0;

    if (data_take) begin
      pending_d   = 1'b0;
      buf_valid_d = 1'b1;
      inst_buf_d  = bus.inst_rdata;
    end

    if (transfer) begin
      fs_valid_d  = 1'b0;
      buf_valid_d = 1'b0;
      fs_ex_d     = 1'b0;
    end

    // A request still outstanding at flush time must have its data swallowed later.
    if (bus.flush) begin
      fs_valid_d  = 1'b0;
      buf_valid_d = 1'b0;
      fs_ex_d     = 1'b0;
      if (pending_d)
        discard_d = 1'b1;
      pending_d   = 1'b0;
    end

    if (req_fire) begin
      fs_valid_d   = 1'b1;
      fs_pc_d      = bus.nextpc;
      fs_ex_d      = bus.ps_to_fs_bus[5];
      fs_exctype_d = bus.ps_to_fs_bus[4:0];
      pending_d    = 1'b1;
      buf_valid_d  = 1'b0;
    end else if (adel_fire) begin
      fs_valid_d   = 1'b1;
      fs_pc_d      = bus.nextpc;
      fs_ex_d      = 1'b1;
      fs_exctype_d = 5'h04;
      pending_d    = 1'b0;
      buf_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid_q   <= 1'b0;
      fs_pc_q      <= RESET_PC;
      fs_ex_q      <= 1'b0;
      fs_exctype_q <= 5'h0;
      pending_q    <= 1'b0;
      discard_q    <= 1'b0;
      buf_valid_q  <= 1'b0;
      inst_buf_q   <= 32'h0;
    end else begin
      fs_valid_q   <= fs_valid_d;
      fs_pc_q      <= fs_pc_d;
      fs_ex_q      <= fs_ex_d;
      fs_exctype_q <= fs_exctype_d;
      pending_q    <= pending_d;
      discard_q    <= discard_d;
      buf_valid_q  <= buf_valid_d;
      inst_buf_q   <= inst_buf_d;
    end
  end

  assign bus.fs_allowin     = fs_allowin;
  assign bus.fs_pc          = fs_pc_q;
  assign bus.fs_to_ds_valid = fs_to_ds_valid;
  assign bus.fs_to_ds_bus   = {fs_ex_q, fs_exctype_q, fs_inst, fs_pc_q};

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: expected decode-bus words are queued as fetches are
// issued and popped by a monitor whenever the stage hands an instruction to decode.
module tb_if_stage;
  localparam logic [31:0] RESET_PC = 32'hbfbffffc;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  logic [69:0] exp_q[$];

  if_stage_if u_if ();

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp_v);
    n_vec++;
    assert (obs === exp_v)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle();
    u_if.nextpc       = 32'hbfc00000;
    u_if.ps_to_fs_bus = 6'h0;
    u_if.inst_valid   = 1'b0;
    u_if.inst_addr_ok = 1'b0;
    u_if.inst_data_ok = 1'b0;
    u_if.inst_rdata   = 32'hdeadbeef;
    u_if.flush        = 1'b0;
    u_if.ds_ex        = 1'b0;
    u_if.es_ex        = 1'b0;
    u_if.m1s_ex       = 1'b0;
  endtask

  task automatic drive_req(input logic [31:0] pc, input logic [5:0] ps);
    u_if.nextpc       = pc;
    u_if.ps_to_fs_bus = ps;
    u_if.inst_valid   = 1'b1;
    u_if.inst_addr_ok = 1'b1;
  endtask

  task automatic drive_data(input logic [31:0] inst);
    u_if.inst_data_ok = 1'b1;
    u_if.inst_rdata   = inst;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset && u_if.fs_to_ds_valid && u_if.ds_allowin) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", u_if.fs_to_ds_bus, 70'h0);
        if (u_if.fs_to_ds_bus === 70'h0) begin
          n_err++;
          $error("FAIL unexpected_out: observed %h expected none", u_if.fs_to_ds_bus);
        end
      end else begin
        chk("ds_bus", u_if.fs_to_ds_bus, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] insts[8];
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    u_if.ds_allowin = 1'b1;
    idle();
    repeat (3) step();
    reset = 1'b0;
    settle();
    chk("rst_valid",   u_if.fs_to_ds_valid, 1'b0);
    chk("rst_pc",      u_if.fs_pc, RESET_PC);
    chk("rst_allowin", u_if.fs_allowin, 1'b1);

    // basic fetch from the boot vector
    step();
    drive_req(32'hbfc00000, 6'h0);
    exp_q.push_back({1'b0, 5'h0, 32'h24080001, 32'hbfc00000});
    step();
    idle();
    drive_data(32'h24080001);
    step();
    idle();
    settle();
    chk("basic_one_cycle", u_if.fs_to_ds_valid, 1'b0);

    // decode stalled while data returns: instruction must be buffered
    step();
    u_if.ds_allowin = 1'b0;
    drive_req(32'hbfc00004, 6'h0);
    exp_q.push_back({1'b0, 5'h0, 32'h8c090010, 32'hbfc00004});
    step();
    idle();
    drive_data(32'h8c090010);
    settle();
    chk("stall_allowin0", u_if.fs_allowin, 1'b0);
    chk("stall_valid",    u_if.fs_to_ds_valid, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step();
      idle();
      u_if.inst_rdata = 32'h0badf00d;
      settle();
      chk("stall_hold_allowin", u_if.fs_allowin, 1'b0);
      chk("stall_hold_pc",      u_if.fs_pc, 32'hbfc00004);
    end
    step();
    u_if.ds_allowin = 1'b1;
    step();
    settle();
    chk("stall_drained", u_if.fs_to_ds_valid, 1'b0);

    // flush while a request is outstanding: its data must be dropped
    step();
    drive_req(32'hbfc00008, 6'h0);
    step();
    idle();
    u_if.flush = 1'b1;
    settle();
    chk("flush_no_out", u_if.fs_to_ds_valid, 1'b0);
    step();
    idle();
    settle();
    chk("flush_allowin", u_if.fs_allowin, 1'b1);
    step();
    drive_req(32'hbfc00380, 6'h0);
    exp_q.push_back({1'b0, 5'h0, 32'h400a6000, 32'hbfc00380});
    step();
    idle();
    drive_data(32'h11111111);
    settle();
    chk("stale_dropped", u_if.fs_to_ds_valid, 1'b0);
    step();
    idle();
    drive_data(32'h400a6000);
    step();
    idle();

    // misaligned fetch address
    u_if.nextpc = 32'hbfc00002;
    exp_q.push_back({1'b1, 5'h04, 32'h0, 32'hbfc00002});
    step();
    idle();
    step();
    settle();
    chk("adel_done", u_if.fs_to_ds_valid, 1'b0);
    u_if.nextpc = 32'hbfc00006;
    u_if.ds_ex  = 1'b1;
    step();
    idle();
    settle();
    chk("adel_blocked_valid", u_if.fs_to_ds_valid, 1'b0);
    chk("adel_blocked_pc",    u_if.fs_pc, 32'hbfc00002);

    // TLB exception carried on the pre-IF bus
    step();
    drive_req(32'hbfc00010, 6'b100010);
    exp_q.push_back({1'b1, 5'h02, 32'h0, 32'hbfc00010});
    step();
    idle();
    settle();
    chk("psex_wait", u_if.fs_to_ds_valid, 1'b0);
    step();
    drive_data(32'h12345678);
    step();
    idle();

    // back-to-back fetches, one per cycle
    for (int i = 0; i < 8; i++) insts[i] = $urandom_range(32'h7fffffff, 0);
    drive_req(32'hbfc00100, 6'h0);
    exp_q.push_back({1'b0, 5'h0, insts[0], 32'hbfc00100});
    for (int i = 1; i <= 8; i++) begin
      step();
      idle();
      drive_data(insts[i-1]);
      if (i < 8) begin
        drive_req(32'hbfc00100 + 32'(i * 4), 6'h0);
        exp_q.push_back({1'b0, 5'h0, insts[i], 32'hbfc00100 + 32'(i * 4)});
      end
      settle();
      chk("b2b_valid", u_if.fs_to_ds_valid, 1'b1);
    end
    step();
    idle();

    // reset in the middle of a request; late data must be ignored
    drive_req(32'hbfc00020, 6'h0);
    step();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive_data(32'h77777777);
    settle();
    chk("midrst_valid", u_if.fs_to_ds_valid, 1'b0);
    chk("midrst_pc",    u_if.fs_pc, RESET_PC);
    step();
    idle();

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    chk("queue_empty", 70'(exp_q.size()), 70'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
